// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that packs a 32-bit word from one of two channels into a
// 7-byte header/tag/data frame and paces it byte-by-byte into a UART transmitter.
module uart_frame_arbiter #(
  parameter logic [7:0] HDR0 = 8'hA5,
  parameter logic [7:0] HDR1 = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        frame_active,
  output logic        grant_id,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [31:0] word, word_n;
  logic        last, last_n;
  logic        tx_start_n;
  logic [7:0]  tx_data_n;
  logic        req0_ready_n, req1_ready_n;
  logic        frame_active_n, grant_id_n;
  logic [15:0] frames_sent_n;
  logic [7:0]  cur_byte;
  logic        pick;

  // Tie goes to the channel not granted last; otherwise whichever is pending.
  assign pick = (req0_valid && req1_valid) ? ~last : req1_valid;

  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      3'd0:    cur_byte = HDR0;
      3'd1:    cur_byte = HDR1;
      3'd2:    cur_byte = {7'd0, grant_id};
      3'd3:    cur_byte = word[31:24];
      3'd4:    cur_byte = word[23:16];
      3'd5:    cur_byte = word[15:8];
      default: cur_byte = word[7:0];
    endcase
  end

  always_comb begin
    state_n        = state;
    idx_n          = idx;
    word_n         = word;
    last_n         = last;
    tx_start_n     = 1'b0;
    tx_data_n      = tx_data;
    req0_ready_n   = 1'b0;
    req1_ready_n   = 1'b0;
    frame_active_n = frame_active;
    grant_id_n     = grant_id;
    frames_sent_n  = frames_sent;
    case (state)
      IDLE: begin
        if (en && (req0_valid || req1_valid)) begin
          word_n         = pick ? req1_data : req0_data;
          last_n         = pick;
          grant_id_n     = pick;
          idx_n          = 3'd0;
          frame_active_n = 1'b1;
          req0_ready_n   = ~pick;
          req1_ready_n   = pick;
          state_n        = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = cur_byte;
          state_n    = GUARD;
        end
      end
      // The transmitter raises busy a cycle late, so busy is not trusted here.
      GUARD: state_n = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (idx != 3'd6) begin
            idx_n   = idx + 3'd1;
            state_n = ISSUE;
          end else begin
            frames_sent_n  = frames_sent + 16'd1;
            frame_active_n = 1'b0;
            state_n        = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 3'd0;
      word         <= 32'd0;
      last         <= 1'b1;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      frame_active <= 1'b0;
      grant_id     <= 1'b0;
      frames_sent  <= 16'd0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      word         <= word_n;
      last         <= last_n;
      tx_start     <= tx_start_n;
      tx_data      <= tx_data_n;
      req0_ready   <= req0_ready_n;
      req1_ready   <= req1_ready_n;
      frame_active <= frame_active_n;
      grant_id     <= grant_id_n;
      frames_sent  <= frames_sent_n;
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed/randomized bench: a byte-queue scoreboard built from granted words,
// a round-robin winner model and a simple busy-counting UART model.
module tb_uart_frame_arbiter;
  localparam logic [7:0] H0 = 8'hA5;
  localparam logic [7:0] H1 = 8'h5A;

  logic        clk, rst, en;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        tx_start, tx_busy, frame_active, grant_id;
  logic [7:0]  tx_data;
  logic [15:0] frames_sent;

  uart_frame_arbiter #(.HDR0(H0), .HDR1(H1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .frame_active(frame_active), .grant_id(grant_id), .frames_sent(frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          errors = 0, checks = 0;
  logic [7:0]  exp_q[$];
  logic        m_last;
  logic [15:0] m_frames;
  int          r0_cnt = 0, r1_cnt = 0, start_cnt = 0;
  int          busy_cnt = 0, busy_len = 3;
  logic        hold_busy = 1'b0, rand_busy = 1'b0;
  logic        prev_active = 1'b0;
  logic        reload0 = 1'b0, reload1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic ch, input logic [31:0] w);
    exp_q.push_back(H0);
    exp_q.push_back(H1);
    exp_q.push_back({7'd0, ch});
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // One clock: observe outputs at the falling edge, then update sources and UART model.
  task automatic step();
    logic exp_ch;
    @(negedge clk);
    if (req0_ready || req1_ready) begin
      exp_ch = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 0);
      check("grant_winner", {31'd0, req1_ready}, {31'd0, exp_ch});
      check("grant_id", {31'd0, grant_id}, {31'd0, exp_ch});
      check("active_at_grant", {31'd0, frame_active}, 1);
      push_frame(exp_ch, exp_ch ? req1_data : req0_data);
      m_last = exp_ch;
      if (exp_ch) begin
        r1_cnt++;
        if (reload1) req1_data = $urandom; else req1_valid = 1'b0;
      end else begin
        r0_cnt++;
        if (reload0) req0_data = $urandom; else req0_valid = 1'b0;
      end
    end
    if (tx_start) begin
      start_cnt++;
      check("spurious_start", {31'd0, exp_q.size() == 0}, 0);
      if (exp_q.size() != 0) check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      busy_cnt = rand_busy ? $urandom_range(0, 4) : busy_len;
    end
    if (prev_active && !frame_active) begin
      m_frames = m_frames + 16'd1;
      check("frames_sent", {16'd0, frames_sent}, {16'd0, m_frames});
      check("frame_bytes_left", exp_q.size(), 0);
    end
    prev_active = frame_active;
    tx_busy = hold_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  endtask

  task automatic run_frames(input int n, input int budget);
    int i;
    logic [15:0] goal;
    i = 0;
    goal = m_frames + n[15:0];
    while (m_frames != goal && i < budget) begin
      step();
      i++;
    end
    check("frames_within_budget", {31'd0, m_frames == goal}, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_req0_ready", {31'd0, req0_ready}, 0);
    check("rst_req1_ready", {31'd0, req1_ready}, 0);
    check("rst_frame_active", {31'd0, frame_active}, 0);
    check("rst_grant_id", {31'd0, grant_id}, 0);
    check("rst_frames_sent", {16'd0, frames_sent}, 0);
    exp_q.delete();
    m_last = 1'b1;
    m_frames = 16'd0;
    prev_active = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    busy_cnt = 0;
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, i, r_before;
    rst = 1'b1; en = 1'b1; tx_busy = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 32'd0; req1_data = 32'd0;
    m_last = 1'b1; m_frames = 16'd0;
    do_reset();

    // Single ch0 word; also first-start latency.
    req0_valid = 1'b1; req0_data = 32'h12345678;
    step();
    check("ready0_after_grant", {31'd0, req0_ready}, 1);
    step();
    check("first_start_latency", {31'd0, tx_start}, 1);
    run_frames(1, 200);
    check("single_ready0_count", r0_cnt, 1);
    check("single_start_count", start_cnt, 7);
    check("single_frames_sent", {16'd0, frames_sent}, 1);

    // Simultaneous requests after reset: ch0 then ch1.
    do_reset();
    req0_valid = 1'b1; req0_data = 32'hAAAA0001;
    req1_valid = 1'b1; req1_data = 32'hBBBB0002;
    run_frames(1, 200);
    check("tie_first_grant", {31'd0, grant_id}, 0);
    run_frames(1, 200);
    check("tie_second_grant", {31'd0, grant_id}, 1);

    // ch1 held continuously, ch0 joins mid-frame: must alternate.
    rand_busy = 1'b1;
    s0 = r0_cnt; s1 = r1_cnt;
    reload1 = 1'b1; req1_valid = 1'b1; req1_data = $urandom;
    repeat (5) step();
    reload0 = 1'b1; req0_valid = 1'b1; req0_data = $urandom;
    run_frames(4, 400);
    check("alt_ch0_grants", r0_cnt - s0, 2);
    check("alt_ch1_grants", r1_cnt - s1, 2);
    reload0 = 1'b0; reload1 = 1'b0;
    run_frames(2, 400);
    rand_busy = 1'b0;

    // Busy held high in ISSUE; en dropped mid-frame must not abort it.
    hold_busy = 1'b1; tx_busy = 1'b1;
    req0_valid = 1'b1; req0_data = $urandom;
    s0 = start_cnt;
    step();
    en = 1'b0;
    repeat (50) step();
    check("no_start_while_busy", start_cnt - s0, 0);
    hold_busy = 1'b0;
    run_frames(1, 200);
    check("one_start_per_byte", start_cnt - s0, 7);
    en = 1'b1;

    // Reset after the fourth byte has started.
    req0_valid = 1'b1; req0_data = $urandom;
    s0 = start_cnt;
    i = 0;
    while (start_cnt < s0 + 4 && i < 200) begin step(); i++; end
    check("reached_byte4", start_cnt - s0, 4);
    do_reset();
    s1 = start_cnt;
    repeat (10) step();
    check("no_start_after_reset", start_cnt - s1, 0);
    check("idle_after_reset", {31'd0, frame_active}, 0);
    req0_valid = 1'b1; req0_data = 32'hCAFEF00D;
    run_frames(1, 200);

    // frames_sent wrap, then en=0 blocks grants.
    @(negedge clk);
    force dut.frames_sent = 16'hFFFF;
    #1;
    release dut.frames_sent;
    m_frames = 16'hFFFF;
    check("preload_frames", {16'd0, frames_sent}, 32'h0000FFFF);
    req1_valid = 1'b1; req1_data = $urandom;
    run_frames(1, 200);
    check("frames_wrap", {16'd0, frames_sent}, 0);
    en = 1'b0;
    req1_valid = 1'b1; req1_data = $urandom;
    r_before = r0_cnt + r1_cnt;
    repeat (20) step();
    check("en_low_no_ready", r0_cnt + r1_cnt - r_before, 0);
    check("en_low_no_frame", {31'd0, frame_active}, 0);
    en = 1'b1;
    run_frames(1, 200);
    check("en_high_grant", r0_cnt + r1_cnt - r_before, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
